// File: rtl/cmd_reply_packer_pkg.sv
// Shared inband packet constants, FSM state type and header word builders
// for the command-reply packer.
package cmd_reply_packer_pkg;

  localparam int unsigned PKT_WORDS       = 256;
  localparam int unsigned HDR_WORDS       = 4;
  localparam int unsigned MAX_PAYLOAD     = 252;
  localparam int unsigned HDR_OVERRUN_BIT = 12;
  localparam int unsigned HDR_START_BIT   = 11;
  localparam int unsigned HDR_END_BIT     = 10;
  localparam int unsigned HDR_CHAN_MSB    = 9;
  localparam int unsigned HDR_CHAN_LSB    = 5;
  localparam logic [4:0]  CTRL_CHANNEL    = 5'h1F;

  typedef enum logic [2:0] {
    ST_EMPTY      = 3'd0,
    ST_COLLECT    = 3'd1,
    ST_WAIT_SPACE = 3'd2,
    ST_SEND       = 3'd3
  } state_t;

  // Payload never exceeds 252 words, so the byte length fits in 9 bits.
  function automatic logic [15:0] hdr_len_word(input logic [7:0] words);
    return {7'd0, words, 1'b0};
  endfunction

  function automatic logic [15:0] hdr_flags_word(input logic       overrun,
                                                 input logic [4:0] channel);
    logic [15:0] w;
    w                              = '0;
    w[HDR_OVERRUN_BIT]             = overrun;
    w[HDR_START_BIT]               = 1'b1;
    w[HDR_END_BIT]                 = 1'b1;
    w[HDR_CHAN_MSB:HDR_CHAN_LSB]   = channel;
    return w;
  endfunction

endpackage

// File: rtl/cmd_reply_packer_reply_buffer.sv
// Packet staging RAM: 256x16 simple dual-port, one write port and a
// registered read port (1-cycle read latency).
module reply_buffer
  import cmd_reply_packer_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem [PKT_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cmd_reply_packer.sv
// Packs command-reader reply words into fixed 256-word control packets for
// the RX FIFO. Optional idle-count flushing is enabled by REPLY_IDLE_FLUSH_EN.
module cmd_reply_packer
  import cmd_reply_packer_pkg::*;
#(
  parameter int unsigned FLUSH_IDLE = 64,
  parameter logic [4:0]  CHANNEL    = CTRL_CHANNEL
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [31:0] timestamp_clock,
  input  logic        rx_WR,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  input  logic        have_space,
  output logic        wrreq,
  output logic [15:0] fifo_data,
  output logic [7:0]  debug
);

  if (FLUSH_IDLE < 1 || FLUSH_IDLE > 255) begin : g_flush_idle_range
    $error("cmd_reply_packer: FLUSH_IDLE must be in 1..255");
  end

  localparam logic [8:0] MAX_WORDS = 9'(MAX_PAYLOAD);
  // Reads run 0..255; two more cycles drain the RAM and output registers.
  localparam logic [8:0] LAST_SEND = 9'(PKT_WORDS + 1);

  state_t      state, state_next;
  logic [8:0]  words, words_inc;
  logic        overrun, pkt_overrun;
  logic [31:0] ts;
  logic [8:0]  send_cnt;
  logic        rd_valid;
  logic [7:0]  rd_idx;
  logic [7:0]  wr_addr;
  logic [15:0] rd_data, out_word;
  logic        accept, store, drop, flush;
  logic        send_start, send_done;

  always_comb begin
    accept    = (state == ST_EMPTY) || ((state == ST_COLLECT) && (words < MAX_WORDS));
    store     = rx_WR && accept;
    drop      = rx_WR && !accept;
    words_inc = words + {8'd0, store};
    wr_addr   = 8'(HDR_WORDS) + words[7:0];
  end

`ifdef REPLY_IDLE_FLUSH_EN
  logic [7:0] idle_cnt;
  logic       idle_cycle;

  assign idle_cycle = (state == ST_COLLECT) && rx_WR_done && !rx_WR;
  assign flush      = idle_cycle && (idle_cnt == 8'(FLUSH_IDLE - 1));

  always_ff @(posedge txclk) begin
    if (reset || !idle_cycle) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  logic done_q;

  // A word arriving with the rising edge is stored before the flush starts.
  assign flush = (state == ST_COLLECT) && rx_WR_done && !done_q && (words_inc != '0);

  always_ff @(posedge txclk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= rx_WR_done;
    end
  end
`endif

  assign send_start = (state == ST_WAIT_SPACE) && have_space;
  assign send_done  = (state == ST_SEND) && (send_cnt == LAST_SEND);

  always_ff @(posedge txclk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    rx_WR_enabled = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        rx_WR_enabled = 1'b1;
        if (store) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        rx_WR_enabled = (words <= MAX_WORDS - 9'd2);
        if ((words_inc == MAX_WORDS) || flush) state_next = ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (have_space) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (send_done) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
    if (reset) rx_WR_enabled = 1'b0;
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      words       <= '0;
      overrun     <= 1'b0;
      pkt_overrun <= 1'b0;
      ts          <= '0;
      send_cnt    <= '0;
      rd_valid    <= 1'b0;
      rd_idx      <= '0;
      wrreq       <= 1'b0;
      fifo_data   <= '0;
    end else begin
      if (store) begin
        words <= words_inc;
        if (state == ST_EMPTY) ts <= timestamp_clock;
      end
      // Drops after the header snapshot belong to the following packet.
      if (send_start) begin
        pkt_overrun <= overrun | drop;
        overrun     <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
      if (send_done) begin
        words       <= '0;
        pkt_overrun <= 1'b0;
      end
      send_cnt  <= ((state == ST_SEND) && !send_done) ? send_cnt + 9'd1 : '0;
      rd_valid  <= (state == ST_SEND) && !send_cnt[8];
      rd_idx    <= send_cnt[7:0];
      wrreq     <= rd_valid;
      fifo_data <= rd_valid ? out_word : '0;
    end
  end

  always_comb begin
    out_word = '0;
    unique case (rd_idx)
      8'd0:    out_word = hdr_len_word(words[7:0]);
      8'd1:    out_word = hdr_flags_word(pkt_overrun, CHANNEL);
      8'd2:    out_word = ts[15:0];
      8'd3:    out_word = ts[31:16];
      default: if ({1'b0, rd_idx} < words + 9'(HDR_WORDS)) out_word = rd_data;
    endcase
  end

  reply_buffer u_reply_buffer (
    .clk     (txclk),
    .wr_en   (store),
    .wr_addr (wr_addr),
    .wr_data (rx_databus),
    .rd_addr (send_cnt[7:0]),
    .rd_data (rd_data)
  );

  assign debug = {state, overrun, words[8:5]};

endmodule

// File: tb/tb_cmd_reply_packer.sv
// Self-checking bench for cmd_reply_packer: directed scenarios plus random
// replies compared against a queue-based packet model.
module tb_cmd_reply_packer;

  localparam int unsigned FLUSH_IDLE = 64;
  localparam int unsigned TIMEOUT    = 2000;

  logic        txclk = 1'b0;
  logic        reset;
  logic [31:0] timestamp_clock;
  logic        rx_WR;
  logic [15:0] rx_databus;
  logic        rx_WR_done;
  logic        rx_WR_enabled;
  logic        have_space;
  logic        wrreq;
  logic [15:0] fifo_data;
  logic [7:0]  debug;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [15:0] pend[$];
  logic [15:0] got[$];
  logic [31:0] ts_exp;
  bit          ovr_exp   = 1'b0;
  bit          ovr_carry = 1'b0;
  bit          aborted;

  always #5 txclk = ~txclk;

  cmd_reply_packer #(
    .FLUSH_IDLE (FLUSH_IDLE),
    .CHANNEL    (5'h1F)
  ) dut (
    .txclk           (txclk),
    .reset           (reset),
    .timestamp_clock (timestamp_clock),
    .rx_WR           (rx_WR),
    .rx_databus      (rx_databus),
    .rx_WR_done      (rx_WR_done),
    .rx_WR_enabled   (rx_WR_enabled),
    .have_space      (have_space),
    .wrreq           (wrreq),
    .fifo_data       (fifo_data),
    .debug           (debug)
  );

  task automatic tick();
    @(posedge txclk);
    #1;
    timestamp_clock = $urandom;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  task automatic drive_word(input logic [15:0] d);
    rx_WR      = 1'b1;
    rx_databus = d;
    rx_WR_done = 1'b0;
    check("wr_enabled", rx_WR_enabled, (pend.size() <= 250));
    if (pend.size() == 0) ts_exp = timestamp_clock;
    if (pend.size() < 252) pend.push_back(d);
    tick();
    rx_WR = 1'b0;
  endtask

  task automatic drive_reply(input int n);
    for (int i = 0; i < n; i++) drive_word(16'($urandom));
  endtask

  task automatic end_reply();
    rx_WR_done = 1'b1;
`ifdef REPLY_IDLE_FLUSH_EN
    repeat (FLUSH_IDLE) tick();
`else
    tick();
`endif
  endtask

  task automatic wait_packet(input int inject_at, input int reset_at, output bit ab);
    int          seen    = 0;
    int unsigned cyc     = 0;
    logic        last_en = 1'bx;
    got.delete();
    ab = 1'b0;
    while (cyc < TIMEOUT) begin
      if (wrreq) begin
        got.push_back(fifo_data);
        seen++;
        last_en = rx_WR_enabled;
        if (seen == reset_at) begin
          reset = 1'b1;
          tick();
          check("reset_wrreq", wrreq, 0);
          check("reset_wr_enabled", rx_WR_enabled, 0);
          reset = 1'b0;
          tick();
          check("post_reset_wr_enabled", rx_WR_enabled, 1);
          pend.delete();
          ovr_exp   = 1'b0;
          ovr_carry = 1'b0;
          ab        = 1'b1;
          return;
        end
        if (seen == inject_at) begin
          rx_WR      = 1'b1;
          rx_databus = 16'hBEEF;
          ovr_carry  = 1'b1;
        end
      end else if (seen > 0) begin
        break;
      end
      tick();
      rx_WR = 1'b0;
      cyc++;
    end
    check("packet_timeout", (cyc < TIMEOUT), 1);
    check("send_wr_enabled", last_en, 0);
    check("empty_after_send", rx_WR_enabled, 1);
  endtask

  task automatic check_packet(input string name);
    logic [15:0] e;
    check({name, "_len"}, got.size(), 256);
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      e = 16'(pend.size() * 2);
      else if (i == 1) e = 16'((ovr_exp ? (1 << 12) : 0) | (1 << 11) | (1 << 10) | (32'h1F << 5));
      else if (i == 2) e = ts_exp[15:0];
      else if (i == 3) e = ts_exp[31:16];
      else if (i - 4 < pend.size()) e = pend[i - 4];
      else             e = 16'h0000;
      check($sformatf("%s_w%0d", name, i), got_at(i), e);
    end
    pend.delete();
    ovr_exp   = ovr_carry;
    ovr_carry = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    rx_WR           = 1'b0;
    rx_databus      = '0;
    rx_WR_done      = 1'b1;
    have_space      = 1'b1;
    timestamp_clock = '0;
    repeat (3) tick();
    check("reset_wrreq", wrreq, 0);
    check("reset_fifo_data", fifo_data, 0);
    check("reset_debug", debug, 0);
    check("reset_wr_enabled", rx_WR_enabled, 0);
    reset = 1'b0;
    tick();
    check("after_reset_wr_enabled", rx_WR_enabled, 1);

    // Ping reply
    drive_word(16'h1234);
    drive_word(16'h0102);
    end_reply();
    wait_packet(-1, -1, aborted);
    check("ping_w0", got_at(0), 16'h0004);
    check("ping_w1", got_at(1), 16'h0FE0);
    check("ping_w4", got_at(4), 16'h1234);
    check_packet("ping");

    // Two register-read replies, one packet each
    for (int r = 0; r < 2; r++) begin
      drive_reply(4);
      end_reply();
      wait_packet(-1, -1, aborted);
      check("regrd_w0", got_at(0), 16'h0008);
      check_packet("regrd");
    end

    // Full packet: 126 back-to-back pairs
    drive_reply(252);
    check("full_wr_enabled", rx_WR_enabled, 0);
    rx_WR_done = 1'b1;
    wait_packet(-1, -1, aborted);
    check("full_w0", got_at(0), 16'h01F8);
    check_packet("full");

    // Backpressure
    have_space = 1'b0;
    drive_reply(6);
    end_reply();
    for (int i = 0; i < 100; i++) begin
      tick();
      check("bp_hold", {wrreq, rx_WR_enabled}, 2'b00);
    end
    have_space = 1'b1;
    tick();
    check("bp_lat0", wrreq, 0);
    tick();
    check("bp_lat1", wrreq, 0);
    tick();
    check("bp_first", wrreq, 1);
    wait_packet(-1, -1, aborted);
    check_packet("bp");

    // Overrun during SEND, reported in the next packet only
    drive_reply(2);
    end_reply();
    wait_packet(50, -1, aborted);
    check_packet("ovr_a");
    drive_reply(2);
    end_reply();
    wait_packet(-1, -1, aborted);
    check("ovr_b_w1", got_at(1), 16'h1FE0);
    check_packet("ovr_b");
    drive_reply(2);
    end_reply();
    wait_packet(-1, -1, aborted);
    check("ovr_c_w1", got_at(1), 16'h0FE0);
    check_packet("ovr_c");

    // Reset at SEND word 100, then a clean single pair
    drive_reply(10);
    end_reply();
    wait_packet(-1, 100, aborted);
    check("reset_abort_seen", aborted, 1);
    drive_reply(2);
    end_reply();
    wait_packet(-1, -1, aborted);
    check("post_reset_w0", got_at(0), 16'h0004);
    check_packet("post_reset");

    // Random replies with random backpressure
    for (int p = 0; p < 6; p++) begin
      have_space = 1'($urandom_range(0, 1));
      drive_reply(2 * int'($urandom_range(1, 40)));
      end_reply();
      if (!have_space) begin
        repeat ($urandom_range(1, 8)) tick();
        have_space = 1'b1;
      end
      wait_packet(-1, -1, aborted);
      check_packet("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
